l1d_cache_param: RTL and testbench

L1D_CACHE_PARAM -- requirements
Module: l1d_cache_param

---
 rtl/l1d_cache_param.sv | 153 +++++++++++++++
 tb/tb_l1d_cache_param.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_cache_param.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Refills read one word at a time with a single read outstanding; stores always go to memory.
module l1d_cache_param #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_busy,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int LIN_W = OFF_W + IDX_W;
   localparam int TAG_W = ADDR_W - LIN_W;
   localparam logic [OFF_W-1:0] LAST_K = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      HIT_RESP,
      RF_CMD,
      RF_WAIT,
      WR_CMD,
      DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [OFF_W-1:0]  r_k;
   logic [SETS-1:0]   r_valid;
   logic [TAG_W-1:0]  r_tag  [SETS];
   logic [DATA_W-1:0] r_data [SETS*LINE_WORDS];
   logic [DATA_W-1:0] r_rdata;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;

   logic [IDX_W-1:0]  w_req_idx;
   logic [TAG_W-1:0]  w_req_tag;
   logic              w_req_hit;
   logic [IDX_W-1:0]  w_lat_idx;
   logic [TAG_W-1:0]  w_lat_tag;
   logic              w_lat_hit;
   logic              w_accept;
   logic              w_rf_beat;
   logic              w_rf_last;
   logic              w_wr_fire;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign w_req_idx = cpu_addr[LIN_W-1:OFF_W];
   assign w_req_tag = cpu_addr[ADDR_W-1:LIN_W];
   assign w_req_hit = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
   assign w_lat_idx = r_addr[LIN_W-1:OFF_W];
   assign w_lat_tag = r_addr[ADDR_W-1:LIN_W];
   assign w_lat_hit = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);

   assign w_accept  = (r_state == IDLE) && cpu_req;
   assign w_rf_beat = (r_state == RF_WAIT) && mem_rvalid;
   assign w_rf_last = w_rf_beat && (r_k == LAST_K);
   assign w_wr_fire = (r_state == WR_CMD) && mem_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (cpu_req) w_next = cpu_we ? WR_CMD : (w_req_hit ? HIT_RESP : RF_CMD);
         HIT_RESP: w_next = IDLE;
         RF_CMD:   if (mem_ready) w_next = RF_WAIT;
         RF_WAIT:  if (mem_rvalid) w_next = (r_k == LAST_K) ? DONE : RF_CMD;
         WR_CMD:   if (mem_ready) w_next = DONE;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_k        <= '0;
         r_valid    <= '0;
         r_rdata    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_k     <= '0;
            if (!cpu_we) begin
               if (w_req_hit) begin
                  r_rdata   <= r_data[cpu_addr[LIN_W-1:0]];
                  r_hit_cnt <= sat_inc(r_hit_cnt);
               end else begin
                  // The refill overwrites the line word by word, so it is invalid until complete.
                  r_valid[w_req_idx] <= 1'b0;
                  r_miss_cnt         <= sat_inc(r_miss_cnt);
               end
            end
         end
         if (w_rf_beat) r_k <= r_k + 1'b1;
         if (w_rf_last) begin
            r_valid[w_lat_idx] <= 1'b1;
            r_rdata <= (r_addr[OFF_W-1:0] == LAST_K) ? mem_rdata : r_data[r_addr[LIN_W-1:0]];
         end
         if (w_wr_fire) begin
            if (w_lat_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
            else           r_miss_cnt <= sat_inc(r_miss_cnt);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_rf_beat) r_data[{w_lat_idx, r_k}] <= mem_rdata;
      if (w_rf_last) r_tag[w_lat_idx] <= w_lat_tag;
      if (w_wr_fire && w_lat_hit) r_data[r_addr[LIN_W-1:0]] <= r_wdata;
   end

   assign cpu_ack   = (r_state == HIT_RESP) || (r_state == DONE);
   assign cpu_busy  = (r_state != IDLE);
   assign cpu_rdata = r_rdata;
   assign mem_valid = (r_state == RF_CMD) || (r_state == WR_CMD);
   assign mem_we    = (r_state == WR_CMD);
   assign mem_addr  = (r_state == WR_CMD) ? r_addr : {r_addr[ADDR_W-1:OFF_W], r_k};
   assign mem_wdata = r_wdata;
   assign hit_cnt   = r_hit_cnt;
   assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_l1d_cache_param.sv
// Bench for l1d_cache_param: directed vector table, reset-abort sequence and random traffic
// against a set/tag model backed by a memory responder with variable latency.
module tb_l1d_cache_param;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_busy;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   always #5 CLK = ~CLK;

   l1d_cache_param dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .cpu_busy   (cpu_busy),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Memory contents seen by the responder; unwritten words follow a fixed pattern.
   logic [31:0] mem_m [logic [31:0]];

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
   endfunction

   int          cfg_ready_dly = 0;   // -1: random 0..3
   int          cfg_rv_dly = 0;      // -1: random 0..2
   bit          cfg_noise = 1'b0;    // stray mem_rvalid pulses outside refill waits
   bit          busy_noise = 1'b0;   // stray cpu_req pulses while busy
   int          rv_given = 0;
   int          stab_err = 0;
   logic [64:0] got_q[$];
   logic [64:0] exp_q[$];

   initial begin : responder
      int          wait_cnt;
      int          target;
      int          rv_cnt;
      bit          pend;
      bit          have_first;
      logic [64:0] first_cmd;
      logic [64:0] cmd;
      logic [31:0] rd_addr;
      wait_cnt = 0; target = 0; rv_cnt = 0; pend = 0; have_first = 0;
      first_cmd = '0; rd_addr = '0;
      forever begin
         @(posedge CLK); #1;
         mem_ready = 1'b0;
         mem_rvalid = 1'b0;
         if (!RST_N) begin
            pend = 0;
            have_first = 0;
            continue;
         end
         if (mem_valid) begin
            cmd = {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
            if (!have_first) begin
               have_first = 1;
               first_cmd = cmd;
               wait_cnt = 0;
               target = (cfg_ready_dly < 0) ? int'($urandom_range(0, 3)) : cfg_ready_dly;
            end else if (cmd !== first_cmd) begin
               stab_err++;
            end
            if (wait_cnt >= target) begin
               mem_ready = 1'b1;
               got_q.push_back(cmd);
               have_first = 0;
               if (!mem_we) begin
                  pend = 1;
                  rd_addr = mem_addr;
                  rv_cnt = (cfg_rv_dly < 0) ? int'($urandom_range(0, 2)) : cfg_rv_dly;
               end else begin
                  mem_m[mem_addr] = mem_wdata;
               end
            end else begin
               wait_cnt++;
            end
         end else if (pend) begin
            if (rv_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = mem_val(rd_addr);
               pend = 0;
               rv_given++;
            end else begin
               rv_cnt--;
            end
         end else if (cfg_noise && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'hDEAD_0000 | 32'($urandom_range(0, 65535));
         end
      end
   end

   // Reference model: which line each set holds, from the address split rules.
   bit          m_valid [16];
   int unsigned m_tag   [16];
   int          e_hc = 0;
   int          e_mc = 0;
   logic [31:0] last_rdata_exp = '0;

   function automatic bit model_hit(input logic [31:0] a);
      int unsigned idx;
      idx = (a / 4) % 16;
      return m_valid[idx] && (m_tag[idx] == a / 64);
   endfunction

   task automatic model_update(input logic we, input logic [31:0] a, input bit hit);
      int unsigned idx;
      idx = (a / 4) % 16;
      if (!we && !hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx] = a / 64;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      e_hc = 0;
      e_mc = 0;
      last_rdata_exp = '0;
   endtask

   task automatic push_exp(input logic we, input logic [31:0] a, input logic [31:0] d, input bit hit);
      if (we) exp_q.push_back({1'b1, a, d});
      else if (!hit) for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, (a & ~32'h3) + 32'(k), 32'h0});
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, " cpu_ack"}, 65'(cpu_ack), 65'd0);
      check({name, " cpu_busy"}, 65'(cpu_busy), 65'd0);
      check({name, " mem_valid"}, 65'(mem_valid), 65'd0);
      check({name, " mem_we"}, 65'(mem_we), 65'd0);
      check({name, " mem_addr"}, 65'(mem_addr), 65'd0);
      check({name, " mem_wdata"}, 65'(mem_wdata), 65'd0);
      check({name, " cpu_rdata"}, 65'(cpu_rdata), 65'd0);
      check({name, " hit_cnt"}, 65'(hit_cnt), 65'd0);
      check({name, " miss_cnt"}, 65'(miss_cnt), 65'd0);
   endtask

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input int exp_lat, input int exp_hc,
                            input int exp_mc, input string name);
      int lat;
      bit acked;
      bit busy_bad;
      lat = 0; acked = 0; busy_bad = 0;
      @(posedge CLK); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      for (int c = 1; c <= 200; c++) begin
         @(posedge CLK); #1;
         if (cpu_busy !== 1'b1) busy_bad = 1;
         if (cpu_ack === 1'b1) begin
            acked = 1;
            lat = c;
            cpu_req = 1'b0;
            break;
         end
         if (busy_noise) begin
            cpu_req = 1'($urandom_range(0, 1));
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 32'($urandom_range(0, 511));
            cpu_wdata = $urandom;
         end else begin
            cpu_req = 1'b0;
         end
      end
      cpu_req = 1'b0;
      check({name, " ack_seen"}, 65'(acked), 65'd1);
      if (acked) begin
         if (!we) begin
            check({name, " rdata"}, 65'(cpu_rdata), 65'(exp_rdata));
            last_rdata_exp = exp_rdata;
         end
         if (exp_lat > 0) check({name, " latency"}, 65'(lat), 65'(exp_lat));
      end
      check({name, " busy_until_ack"}, 65'(busy_bad), 65'd0);
      @(posedge CLK); #1;
      check({name, " ack_one_cycle"}, 65'(cpu_ack), 65'd0);
      check({name, " busy_drop"}, 65'(cpu_busy), 65'd0);
      check({name, " rdata_hold"}, 65'(cpu_rdata), 65'(last_rdata_exp));
      check({name, " mem_cmd_count"}, 65'(got_q.size()), 65'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s mem_cmd%0d", name, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
      check({name, " cmd_stable"}, 65'(stab_err), 65'd0);
      stab_err = 0;
      check({name, " hit_cnt"}, 65'(hit_cnt), 65'(exp_hc));
      check({name, " miss_cnt"}, 65'(miss_cnt), 65'(exp_mc));
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ready_dly;
      logic [31:0] exp_rdata;
      bit          exp_hit;
      int          exp_lat;
      int          exp_hc;
      int          exp_mc;
   } vec_t;

   vec_t vecs [10];

   initial begin : main
      int  base;
      bit  got2;
      for (int k = 0; k < 4; k++) begin
         mem_m[32'h40 + 32'(k)]  = 32'hA0 + 32'(k);
         mem_m[32'h44 + 32'(k)]  = 32'hE0 + 32'(k);
         mem_m[32'h140 + 32'(k)] = 32'hC0 + 32'(k);
         mem_m[32'h200 + 32'(k)] = 32'hD0 + 32'(k);
      end
      //           we    addr      wdata    rdy  rdata     hit   lat hc mc
      vecs[0] = '{1'b0, 32'h040, 32'h0,  0, 32'hA0, 1'b0, 9, 0, 1};
      vecs[1] = '{1'b0, 32'h042, 32'h0,  0, 32'hA2, 1'b1, 1, 1, 1};
      vecs[2] = '{1'b1, 32'h041, 32'h55, 3, 32'h0,  1'b1, 5, 2, 1};
      vecs[3] = '{1'b0, 32'h041, 32'h0,  0, 32'h55, 1'b1, 1, 3, 1};
      vecs[4] = '{1'b0, 32'h140, 32'h0,  0, 32'hC0, 1'b0, 9, 3, 2};
      vecs[5] = '{1'b0, 32'h040, 32'h0,  0, 32'hA0, 1'b0, 9, 3, 3};
      vecs[6] = '{1'b1, 32'h200, 32'h77, 0, 32'h0,  1'b0, 2, 3, 4};
      vecs[7] = '{1'b0, 32'h200, 32'h0,  0, 32'h77, 1'b0, 9, 3, 5};
      vecs[8] = '{1'b0, 32'h203, 32'h0,  0, 32'hD3, 1'b1, 1, 4, 5};
      vecs[9] = '{1'b0, 32'h047, 32'h0,  0, 32'hE3, 1'b0, 9, 4, 6};

      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check_outputs_zero("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cfg_ready_dly = vecs[i].ready_dly;
         cfg_rv_dly = 0;
         push_exp(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_hit);
         model_update(vecs[i].we, vecs[i].addr, vecs[i].exp_hit);
         do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat,
                   vecs[i].exp_hc, vecs[i].exp_mc, $sformatf("v%0d", i));
      end

      // Reset in the middle of a refill: two words in, then abort.
      cfg_ready_dly = 0;
      cfg_rv_dly = 0;
      base = rv_given;
      got2 = 0;
      @(posedge CLK); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
      @(posedge CLK); #1;
      cpu_req = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge CLK); #2;
         if (rv_given - base >= 2) begin
            got2 = 1;
            break;
         end
      end
      check("rst_mid two_words", 65'(got2), 65'd1);
      @(posedge CLK); #2;
      RST_N = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      repeat (2) @(posedge CLK);
      #3;
      RST_N = 1'b1;
      got_q.delete();
      exp_q.delete();
      stab_err = 0;
      model_reset();
      push_exp(1'b0, 32'h40, 32'h0, 1'b0);
      model_update(1'b0, 32'h40, 1'b0);
      do_access(1'b0, 32'h40, 32'h0, 32'hA0, 9, 0, 1, "after_rst");
      e_mc = 1;

      // Random traffic over 4 tags x 16 sets with random memory latency and stray inputs.
      cfg_ready_dly = -1;
      cfg_rv_dly = -1;
      cfg_noise = 1'b1;
      busy_noise = 1'b1;
      for (int n = 0; n < 150; n++) begin
         logic        we;
         logic [31:0] a;
         logic [31:0] d;
         logic [31:0] er;
         bit          hit;
         we = ($urandom_range(0, 2) == 0);
         a = 32'($urandom_range(0, 255));
         d = $urandom;
         hit = model_hit(a);
         er = mem_val(a);
         push_exp(we, a, d, hit);
         if (hit) e_hc++;
         else e_mc++;
         model_update(we, a, hit);
         do_access(we, a, d, er, (hit && !we) ? 1 : 0, e_hc, e_mc, $sformatf("r%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      failures++;
      $display("FAIL watchdog time_limit_reached actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
